// File: rtl/rtc_pkg.sv
// Shared types and defaults for the stopwatch button-conditioning logic.
package rtc_pkg;

    // Debouncer / press-tracking FSM states.
    typedef enum logic [2:0] {
        ST_ARMING       = 3'd0,
        ST_IDLE         = 3'd1,
        ST_PRESS_WAIT   = 3'd2,
        ST_PRESSED      = 3'd3,
        ST_HELD         = 3'd4,
        ST_RELEASE_WAIT = 3'd5
    } rtc_btn_state_t;

    // 10 ms debounce and 2 s hold at a 100 MHz system clock.
    localparam int RTC_DEBOUNCE_DEFAULT  = 1_000_000;
    localparam int RTC_LONGPRESS_DEFAULT = 200_000_000;

    // Width of a counter that must hold 0 .. n-1 (never narrower than one bit).
    function automatic int rtc_count_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rtc_sync2.sv
// Two-flop synchroniser for a single asynchronous input, with synchronous
// active-high reset. Shared by every board button that feeds the stopwatch.
module rtc_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    // Shift the raw pin through two flops; the first may go metastable.
    // NOTE: sequential state always uses non-blocking (<=) so every flop
    // samples the pre-edge value of its neighbour and the order of
    // statements inside the block does not matter.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/rtc_button_conditioner.sv
// Push-button conditioner: synchronises the raw pin, debounces both edges,
// and emits a registered press pulse, debounced level and long-press pulse.
module rtc_button_conditioner
    import rtc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = RTC_DEBOUNCE_DEFAULT,
    parameter int LONG_PRESS_CYCLES = RTC_LONGPRESS_DEFAULT
) (
    input  logic i_sclk,
    input  logic i_reset,
    input  logic i_button,
    output logic o_trigger,
    output logic o_level,
    output logic o_long_press
);

    localparam int CNT_W = rtc_count_width(DEBOUNCE_CYCLES);
    localparam int HC_W  = rtc_count_width(LONG_PRESS_CYCLES);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HC_W-1:0]  HC_ONE   = HC_W'(1);
    localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(LONG_PRESS_CYCLES - 1);

    logic           s;          // synchronised button
    rtc_btn_state_t state;
    logic [CNT_W-1:0] cnt;      // consecutive agreeing samples
    logic [HC_W-1:0]  hc;       // held cycles since the accepted press
    logic           from_held;  // RELEASE_WAIT returns to HELD when set

    rtc_sync2 u_sync (
        .clk      (i_sclk),
        .reset    (i_reset),
        .async_in (i_button),
        .sync_out (s)
    );

    // Press-tracking FSM, both counters and all three output registers.
    // NOTE: the reset branch is synchronous and wins over every state, so a
    // pulse already registered is cleared on the very next edge.
    always_ff @(posedge i_sclk) begin
        if (i_reset) begin
            state        <= ST_ARMING;
            cnt          <= '0;
            hc           <= '0;
            from_held    <= 1'b0;
            o_trigger    <= 1'b0;
            o_level      <= 1'b0;
            o_long_press <= 1'b0;
        end else begin
            // NOTE: pulses default low here and are raised only by the one
            // transition that fires them, which guarantees one-cycle width.
            o_trigger    <= 1'b0;
            o_long_press <= 1'b0;

            case (state)
                // Wait for a clean released level so a button held through
                // reset is never mistaken for a press.
                ST_ARMING: begin
                    if (s) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                ST_IDLE: begin
                    if (s) begin
                        state <= ST_PRESS_WAIT;
                        cnt   <= CNT_ONE;
                    end
                end

                ST_PRESS_WAIT: begin
                    if (!s) begin
                        state <= ST_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state     <= ST_PRESSED;
                        hc        <= '0;
                        o_trigger <= 1'b1;
                        o_level   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                // Release is checked first so no long press fires on the
                // cycle the button lets go.
                ST_PRESSED: begin
                    if (!s) begin
                        state     <= ST_RELEASE_WAIT;
                        cnt       <= CNT_ONE;
                        from_held <= 1'b0;
                    end else if (hc == HC_LAST) begin
                        state        <= ST_HELD;
                        o_long_press <= 1'b1;
                    end else begin
                        hc <= hc + HC_ONE;
                    end
                end

                ST_HELD: begin
                    if (!s) begin
                        state     <= ST_RELEASE_WAIT;
                        cnt       <= CNT_ONE;
                        from_held <= 1'b1;
                    end
                end

                // hc is left untouched here so a rejected release glitch
                // only pauses the long-press timer.
                ST_RELEASE_WAIT: begin
                    if (s) begin
                        state <= from_held ? ST_HELD : ST_PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        state   <= ST_IDLE;
                        o_level <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: begin
                    state   <= ST_ARMING;
                    cnt     <= '0;
                    o_level <= 1'b0;
                end
            endcase
        end
    end

endmodule
